// File: rtl/e_digit_uart_tx_if.sv
// Digit handshake between the spigot-e engine (master) and the UART formatter (slave).
interface e_digit_uart_tx_if;
    logic       digit_valid;
    logic [3:0] digit;
    logic       digit_ready;

    modport master (output digit_valid, output digit, input digit_ready);
    modport slave  (input digit_valid, input digit, output digit_ready);
endinterface

// File: rtl/e_digit_uart_tx.sv
// Buffers e digits in a small FIFO, formats them as "2.718...\r\n" text and
// transmits the bytes as UART 8N1.
module e_digit_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned LINE_LEN     = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    e_digit_uart_tx_if.slave   up,
    output logic               tx,
    output logic               tx_busy,
    output logic               err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned LW = (LINE_LEN > 1) ? $clog2(LINE_LEN + 1) : 1;

    typedef enum logic [2:0] {StFirst, StDot, StFrac, StCr, StLf} fmt_state_e;
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, push, pop;
    logic [3:0]    head;
    logic [7:0]    head_ascii;
    logic          err_q;

    fmt_state_e    fmt_q, fmt_d;
    logic [LW-1:0] line_q, line_d;
    logic          emit, pending;
    logic [7:0]    emit_byte;

    uart_state_e   uart_q, uart_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          bit_end, uart_ready;

    // ---------------- digit FIFO ----------------
    assign full            = (count_q == CW'(FIFO_DEPTH));
    assign empty           = (count_q == '0);
    assign up.digit_ready  = !full;
    assign push            = up.digit_valid && up.digit_ready;
    assign head            = mem_q[rd_ptr_q];
    assign head_ascii      = (head > 4'd9) ? 8'h3F : {4'h3, head};

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= up.digit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && (up.digit > 4'd9)) err_q <= 1'b1;
        end
    end

    // ---------------- formatter ----------------
    always_comb begin
        fmt_d     = fmt_q;
        line_d    = line_q;
        pop       = 1'b0;
        emit      = 1'b0;
        emit_byte = 8'h00;
        unique case (fmt_q)
            StFirst: if (!empty && uart_ready) begin
                pop       = 1'b1;
                emit      = 1'b1;
                emit_byte = head_ascii;
                fmt_d     = StDot;
            end
            StDot: if (uart_ready) begin
                emit      = 1'b1;
                emit_byte = 8'h2E;
                fmt_d     = StFrac;
            end
            StFrac: if (!empty && uart_ready) begin
                pop       = 1'b1;
                emit      = 1'b1;
                emit_byte = head_ascii;
                if (LINE_LEN != 0 && line_q == LW'(LINE_LEN - 1)) begin
                    line_d = '0;
                    fmt_d  = StCr;
                end else if (LINE_LEN != 0) begin
                    line_d = line_q + 1'b1;
                end
            end
            StCr: if (uart_ready) begin
                emit      = 1'b1;
                emit_byte = 8'h0D;
                fmt_d     = StLf;
            end
            StLf: if (uart_ready) begin
                emit      = 1'b1;
                emit_byte = 8'h0A;
                fmt_d     = StFrac;
            end
            default: fmt_d = StFirst;
        endcase
    end

    // A byte is pending whenever the formatter has something it could emit right now.
    assign pending = (fmt_q inside {StDot, StCr, StLf}) || !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_q  <= StFirst;
            line_q <= '0;
        end else begin
            fmt_q  <= fmt_d;
            line_q <= line_d;
        end
    end

    // ---------------- UART 8N1 ----------------
    assign bit_end    = (timer_q == TW'(CLKS_PER_BIT - 1));
    // Accepting during the last stop cycle keeps back-to-back frames gapless.
    assign uart_ready = (uart_q == StIdle) || (uart_q == StStop && bit_end);

    always_comb begin
        uart_d  = uart_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        data_d  = data_q;
        unique case (uart_q)
            StIdle: ;
            StStart: begin
                timer_d = bit_end ? '0 : timer_q + 1'b1;
                if (bit_end) begin
                    bit_d  = '0;
                    uart_d = StData;
                end
            end
            StData: begin
                timer_d = bit_end ? '0 : timer_q + 1'b1;
                if (bit_end) begin
                    if (bit_q == 3'd7) uart_d = StStop;
                    else               bit_d  = bit_q + 1'b1;
                end
            end
            StStop: begin
                timer_d = bit_end ? '0 : timer_q + 1'b1;
                if (bit_end) uart_d = StIdle;
            end
            default: uart_d = StIdle;
        endcase
        if (emit) begin
            uart_d  = StStart;
            timer_d = '0;
            data_d  = emit_byte;
        end
    end

    // tx is registered, so the line lags the state by one cycle.
    always_comb begin
        unique case (uart_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = data_q[bit_q];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_q  <= StIdle;
            timer_q <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            uart_q  <= uart_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (uart_q != StIdle) || pending;
    assign err     = err_q;
endmodule

// File: tb/tb_e_digit_uart_tx.sv
// Randomised self-checking bench: decodes the UART line and compares against a
// text-level model of the "2.718...\r\n" stream.
module tb_e_digit_uart_tx;
    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LLEN  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx, tx_busy, err;

    e_digit_uart_tx_if bus ();

    always #5 clk = ~clk;

    e_digit_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .LINE_LEN     (LLEN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .up      (bus),
        .tx      (tx),
        .tx_busy (tx_busy),
        .err     (err)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         stalls   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];
    bit         model_first = 0;
    int         model_frac  = 0;
    logic       model_err   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Text-level reference: first digit, '.', then digits with CR/LF every LLEN.
    task automatic model_accept(input logic [3:0] d);
        logic [7:0] a;
        a = (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
        if (d > 4'd9) model_err = 1'b1;
        if (!model_first) begin
            exp_q.push_back(a);
            exp_q.push_back(8'h2E);
            model_first = 1;
        end else begin
            exp_q.push_back(a);
            model_frac++;
            if (LLEN != 0 && (model_frac % LLEN) == 0) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
    endtask

    // UART line decoder, samples mid-bit on falling clock edges.
    initial begin : rx_decoder
        bit         active;
        int         idx;
        int         k;
        logic [7:0] sh;
        active = 0;
        idx    = 0;
        sh     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
            end else if (!active) begin
                if (tx == 1'b0) begin
                    active = 1;
                    idx    = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                idx++;
                if ((idx % CPB) == CPB / 2) begin
                    k = idx / CPB;
                    if (k == 0) check("start_bit", {31'b0, tx}, 32'd0);
                    else if (k <= 8) sh[k-1] = tx;
                    else begin
                        check("stop_bit", {31'b0, tx}, 32'd1);
                        rx_q.push_back(sh);
                        active = 0;
                    end
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic push(input logic [3:0] d);
        int guard;
        guard           = 0;
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        while (bus.digit_ready !== 1'b1) begin
            stalls++;
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                check("push_timeout", 32'd0, 32'd1);
                bus.digit_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_accept(d);
        @(negedge clk);
        check("err", {31'b0, err}, {31'b0, model_err});
    endtask

    task automatic drain(input string tag);
        int guard;
        guard           = 0;
        bus.digit_valid = 1'b0;
        repeat (2) @(negedge clk);
        while (tx_busy && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_drain"}, {31'b0, tx_busy}, 32'd0);
        repeat (2 * CPB) @(negedge clk);
        check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < rx_q.size()) check({tag, "_byte"}, {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        rx_q.delete();
        start_q.delete();
        model_first = 0;
        model_frac  = 0;
        model_err   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_tx",    {31'b0, tx},              32'd1);
        check("rst_busy",  {31'b0, tx_busy},         32'd0);
        check("rst_err",   {31'b0, err},             32'd0);
        check("rst_ready", {31'b0, bus.digit_ready}, 32'd1);
        clear_model();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tx", {31'b0, tx}, 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [9:0] fb;
        logic [7:0] line_exp[9];
        logic [3:0] d;
        int         lows;
        int         guard;

        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;

        // Single digit: exact waveform, start bit two cycles after accept.
        do_reset();
        fb = {1'b1, 8'h32, 1'b0};
        push(4'd2);
        bus.digit_valid = 1'b0;
        for (int i = 0; i < 2 + 10 * CPB; i++) begin
            check("wave", {31'b0, tx}, (i < 2) ? 32'd1 : {31'b0, fb[(i-2)/CPB]});
            @(negedge clk);
        end
        drain("single");

        // Prefix: frames must follow each other with no idle cycles.
        do_reset();
        push(4'd2); push(4'd7); push(4'd1); push(4'd8);
        drain("prefix");
        for (int i = 1; i < start_q.size(); i++)
            check("gap", start_q[i] - start_q[i-1], 10 * CPB);

        // Line break after three fractional digits.
        do_reset();
        push(4'd2); push(4'd7); push(4'd1); push(4'd8); push(4'd2); push(4'd8);
        drain("line");
        line_exp = '{8'h32, 8'h2E, 8'h37, 8'h31, 8'h38, 8'h0D, 8'h0A, 8'h32, 8'h38};
        for (int i = 0; i < 9; i++)
            if (i < rx_q.size()) check("line_lit", {24'b0, rx_q[i]}, {24'b0, line_exp[i]});

        // Backpressure: continuous valid, 20 random digits.
        do_reset();
        stalls = 0;
        for (int i = 0; i < 20; i++) push(4'($urandom_range(0, 9)));
        drain("bp");
        check("bp_stalled", {31'b0, stalls > 0}, 32'd1);

        // Invalid digit: '?' and sticky err.
        do_reset();
        push(4'd2);
        push(4'd12);
        push(4'd5);
        push(4'd3);
        drain("inv");
        check("err_hold", {31'b0, err}, 32'd1);

        // Reset mid-frame: line returns high at once, nothing more is sent.
        do_reset();
        push(4'd5);
        bus.digit_valid = 1'b0;
        guard = 0;
        while (tx !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("midrst_started", {31'b0, tx}, 32'd0);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx",    {31'b0, tx},      32'd1);
        check("midrst_busy",  {31'b0, tx_busy}, 32'd0);
        repeat (3) @(negedge clk);
        clear_model();
        rst_n = 1'b1;
        lows  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("midrst_quiet", lows, 32'd0);
        check("midrst_rx", rx_q.size(), 32'd0);

        // Random stream with idle gaps and occasional invalid digits.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            d = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                            : 4'($urandom_range(0, 9));
            push(d);
            bus.digit_valid = 1'b0;
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        drain("rand");
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/e_digit_uart_tx.md
Name: e_digit_uart_tx

Overview:
- Downstream consumer of the spigot-e digit engine.
- Accepts one decimal digit per valid/ready handshake and buffers it in a small FIFO.
- Formats the stream as ASCII text "2.718281828..." with the decimal point inserted and CR/LF after every LINE_LEN fractional digits.
- Serialises bytes as UART 8N1 on a single output pin, driven to a user-project output of the top level.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200). Minimum 4.
- FIFO_DEPTH, 4, digit FIFO entries. Power of two, at least 2.
- LINE_LEN, 50, fractional digits per output line. 0 disables CR/LF insertion.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- digit_valid  in  1  upstream digit available
- digit  in  4  BCD digit value
- digit_ready  out  1  FIFO can accept; equals !full, combinational from the registered count
- tx  out  1  UART serial output, idle high
- tx_busy  out  1  high while a frame is on the line or a byte is pending
- err  out  1  sticky flag: a digit greater than 9 was accepted

Behaviour:
- Reset (async assert, sync release):
  - tx=1, tx_busy=0, err=0, digit_ready=1.
  - FIFO empty, formatter in FIRST state, line counter 0, UART IDLE.
  - Reset mid-frame aborts the frame: tx returns high immediately and the remainder is not sent.
- FIFO:
  - Push when digit_valid && digit_ready.
  - Pop when the formatter requests the next digit.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push while full cannot occur (ready low). No overflow path.
- Digit to ASCII: value 0-9 maps to 0x30+value. Values 10-15 map to '?' (0x3F) and set err on the accept edge; err stays set until reset.
- Formatter FSM. States: FIRST, DOT, FRAC, CR, LF.
  - FIRST: wait for a FIFO entry, pop it, emit its ASCII, go to DOT.
  - DOT: emit 0x2E, go to FRAC. No pop.
  - FRAC: pop and emit a digit, increment the line counter.
    - If LINE_LEN!=0 and counter reaches LINE_LEN: clear the counter, go to CR.
    - Otherwise stay in FRAC.
  - CR: emit 0x0D, go to LF. LF: emit 0x0A, go to FRAC.
  - A byte is emitted by handing it to the UART only when the UART is IDLE. The formatter stalls otherwise.
  - DOT/CR/LF never wait on the FIFO.
- UART FSM. States: IDLE, START, DATA, STOP.
  - Load on the emit edge. tx goes low on the following edge.
  - START: 1 bit-time low. DATA: 8 bits LSB first, 1 bit-time each. STOP: 1 bit-time high.
  - Bit timer counts 0..CLKS_PER_BIT-1; bit index is 3 bits.
  - At end of STOP return to IDLE.
  - A pending byte may load in the same cycle IDLE is entered, so back-to-back frames have no extra idle cycles.
- Latency: digit accepted at edge N with the FIFO empty and the UART idle gives a pop/emit at edge N+1 and the start bit beginning at edge N+2.
- tx_busy = (UART state != IDLE) || formatter holding an unsent byte.
- Throughput: one byte per 10*CLKS_PER_BIT cycles. Upstream is back-pressured purely through digit_ready.

Test Plan:
- Reset check: hold rst_n low, then release → tx=1, tx_busy=0, err=0, digit_ready=1. Assert rst_n mid-frame → tx=1 within the same cycle and no further frame edges.
- Single digit with CLKS_PER_BIT=4: push digit 2 → tx low 2 cycles after accept, frame bits 0,0,1,0,0,1,1,0,0,1 (start, 0x32 LSB first, stop), each exactly 4 cycles.
- Prefix formatting: push 2,7,1,8 → decoded byte stream 0x32 0x2E 0x37 0x31 0x38 with no idle gaps between frames.
- Line break with LINE_LEN=3: push 2,7,1,8,2,8 → bytes "2" "." "7" "1" "8" 0x0D 0x0A "2" "8".
- Backpressure with FIFO_DEPTH=4: drive digit_valid continuously → digit_ready falls after the FIFO fills and rises once per transmitted digit. No digit lost or duplicated across 20 digits; the decoded sequence matches the pushed sequence.
- Invalid digit: push 2, then 12 → bytes 0x32 0x2E 0x3F; err rises on the accept edge of 12 and stays high through subsequent valid digits until reset.
